// File: rtl/move_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// tetris package
//
// Shared types and constants for the tile-move path.
//   direction_e    : direction request passed to the tile-move executor
//   sched_state_e  : move_scheduler handshake state
//   gravity_*_c    : default gravity timing in clk cycles
//   repeat_*_c     : default auto-repeat timing (used when the
//                    MOVE_SCHEDULER_AUTOREPEAT_EN macro is defined)
//   level_w_c      : width of the game level input
//   key_*_c        : bit positions of the buttons in move_scheduler's key vector
//   gravity_period : level -> gravity period, clamped at the minimum
// -----------------------------------------------------------------------------
package tetris;

    typedef enum logic [1:0] {
        eNon   = 2'd0,
        eDown  = 2'd1,
        eLeft  = 2'd2,
        eRight = 2'd3
    } direction_e;

    typedef enum logic {
        eIDLE = 1'b0,
        eREQ  = 1'b1
    } sched_state_e;

    localparam int level_w_c = 4;

    localparam int gravity_base_period_c = 25000000;
    localparam int gravity_min_period_c  = 2500000;
    localparam int gravity_level_step_c  = 1500000;

    localparam int repeat_delay_c  = 8000000;
    localparam int repeat_period_c = 2000000;

    localparam int key_down_c  = 0;
    localparam int key_left_c  = 1;
    localparam int key_right_c = 2;
    localparam int key_num_c   = 3;

    // Period shrinks linearly with level and bottoms out at min. The clamp is
    // taken on the product so the subtraction can never wrap.
    function automatic logic [31:0] gravity_period(
        input logic [31:0] level,
        input logic [31:0] base,
        input logic [31:0] min,
        input logic [31:0] step
    );
        logic [31:0] product;
        product = level * step;
        if (product >= base - min) begin
            return min;
        end
        return base - product;
    endfunction

endpackage

// File: rtl/move_scheduler_key_event.sv
// -----------------------------------------------------------------------------
// key_event
//
// Per-button event generator. Produces a one-cycle pulse on a rising edge of
// the (already synchronised) button level while the game is running. When the
// MOVE_SCHEDULER_AUTOREPEAT_EN macro is defined and repeat_en_p is set, a held
// button additionally pulses after repeat_delay_p cycles and then every
// repeat_period_p cycles; without the macro no repeat counter exists.
//
// Ports:
//   clk_i    : clock
//   reset_i  : synchronous active-high reset
//   en_i     : game running; low suppresses events and restarts auto-repeat
//   btn_i    : synchronised button level
//   evt_o    : one-cycle event pulse (combinational from btn_i and history)
// -----------------------------------------------------------------------------
module key_event
    import tetris::*;
#(
    parameter int repeat_delay_p  = repeat_delay_c,
    parameter int repeat_period_p = repeat_period_c,
    parameter bit repeat_en_p     = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic en_i,
    input  logic btn_i,
    output logic evt_o
);

    logic btn_prev_reg;
    logic edge_evt;

    // History tracks the button even while paused, so a button held across
    // unpause is seen as "already high" and does not fire.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            btn_prev_reg <= 1'b0;
        end else begin
            btn_prev_reg <= btn_i;
        end
    end

    assign edge_evt = en_i & btn_i & ~btn_prev_reg;

`ifdef MOVE_SCHEDULER_AUTOREPEAT_EN
    localparam int rpt_w_c = $clog2(repeat_delay_p + 1);

    logic [rpt_w_c-1:0] rpt_cnt_reg;
    logic               rpt_evt;

    // The counter equals the cycle count since the rising edge. On reaching
    // the delay it reloads so that it hits the delay again exactly
    // repeat_period_p cycles later.
    assign rpt_evt = repeat_en_p & en_i & btn_i
                   & (rpt_cnt_reg == rpt_w_c'(repeat_delay_p));

    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i || !btn_i) begin
            rpt_cnt_reg <= '0;
        end else if (rpt_evt) begin
            rpt_cnt_reg <= rpt_w_c'(repeat_delay_p - repeat_period_p + 1);
        end else begin
            rpt_cnt_reg <= rpt_cnt_reg + rpt_w_c'(1);
        end
    end

    assign evt_o = edge_evt | rpt_evt;
`else
    assign evt_o = edge_evt;
`endif

endmodule

// File: rtl/move_scheduler.sv
// -----------------------------------------------------------------------------
// move_scheduler
//
// Command source for the tile-move executor. Merges button presses and a
// level-dependent gravity timer into single direction requests, issued one at
// a time over a valid/ready handshake. One pending flag per direction; repeat
// events for a direction merge into its flag.
//
// Build option: define MOVE_SCHEDULER_AUTOREPEAT_EN to enable auto-repeat on
// the left/right buttons (down never repeats). Default build is edge-only.
//
// Ports:
//   clk_i          : clock
//   reset_i        : synchronous active-high reset
//   en_i           : game running; low = pause (flags, counter, request drop)
//   btn_left_i     : synchronised level, left button
//   btn_right_i    : synchronised level, right button
//   btn_down_i     : synchronised level, soft-drop button
//   level_i        : game level 0..15, selects the gravity period
//   v_o            : request valid
//   direction_o    : requested direction, eNon while v_o is low
//   ready_i        : executor ready
//   gravity_tick_o : one-cycle pulse when the gravity period expires
// -----------------------------------------------------------------------------
module move_scheduler
    import tetris::*;
#(
    parameter int base_period_p   = gravity_base_period_c,
    parameter int min_period_p    = gravity_min_period_c,
    parameter int level_step_p    = gravity_level_step_c,
    parameter int repeat_delay_p  = repeat_delay_c,
    parameter int repeat_period_p = repeat_period_c
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 en_i,
    input  logic                 btn_left_i,
    input  logic                 btn_right_i,
    input  logic                 btn_down_i,
    input  logic [level_w_c-1:0] level_i,
    output logic                 v_o,
    output direction_e           direction_o,
    input  logic                 ready_i,
    output logic                 gravity_tick_o
);

    localparam int cnt_w_c = $clog2(base_period_p);

    // ------------------------------------------------------------------
    // Button events
    // ------------------------------------------------------------------
    logic [key_num_c-1:0] btn_vec;
    logic [key_num_c-1:0] evt_vec;

    assign btn_vec[key_down_c]  = btn_down_i;
    assign btn_vec[key_left_c]  = btn_left_i;
    assign btn_vec[key_right_c] = btn_right_i;

    for (genvar gi = 0; gi < key_num_c; gi++) begin : g_key
        key_event #(
            .repeat_delay_p  (repeat_delay_p),
            .repeat_period_p (repeat_period_p),
            .repeat_en_p     (gi != key_down_c)
        ) u_key_event (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .en_i    (en_i),
            .btn_i   (btn_vec[gi]),
            .evt_o   (evt_vec[gi])
        );
    end

    // ------------------------------------------------------------------
    // Gravity timer
    // ------------------------------------------------------------------
    logic [cnt_w_c-1:0] grav_cnt_reg;
    logic               grav_tick_reg;
    logic [31:0]        period;
    logic               grav_fire;

    assign period = gravity_period(32'(level_i), 32'(base_period_p),
                                   32'(min_period_p), 32'(level_step_p));

    // ">=" rather than "==" so that a level increase which shortens the
    // period below the current count still fires immediately.
    assign grav_fire = en_i & (32'(grav_cnt_reg) >= period - 32'd1);

    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i) begin
            grav_cnt_reg  <= '0;
            grav_tick_reg <= 1'b0;
        end else if (grav_fire) begin
            grav_cnt_reg  <= '0;
            grav_tick_reg <= 1'b1;
        end else begin
            grav_cnt_reg  <= grav_cnt_reg + cnt_w_c'(1);
            grav_tick_reg <= 1'b0;
        end
    end

    assign gravity_tick_o = grav_tick_reg;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful in eIDLE)
    // ------------------------------------------------------------------
    sched_state_e state_reg;
    logic         v_reg;
    direction_e   dir_reg;
    logic         pend_down_reg;
    logic         pend_left_reg;
    logic         pend_right_reg;

    direction_e   pick_dir;
    logic         clr_down;
    logic         clr_left;
    logic         clr_right;
    logic         lr_conflict;

    // Left and right pending together cancel each other; down is unaffected
    // and keeps top priority.
    assign lr_conflict = pend_left_reg & pend_right_reg;

    always_comb begin
        pick_dir  = eNon;
        clr_down  = 1'b0;
        clr_left  = 1'b0;
        clr_right = 1'b0;
        if (state_reg == eIDLE) begin
            clr_left  = lr_conflict;
            clr_right = lr_conflict;
            if (pend_down_reg) begin
                pick_dir = eDown;
                clr_down = 1'b1;
            end else if (pend_left_reg && !lr_conflict) begin
                pick_dir = eLeft;
                clr_left = 1'b1;
            end else if (pend_right_reg && !lr_conflict) begin
                pick_dir = eRight;
                clr_right = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending flags and request FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i || !en_i) begin
            // Pause behaves like reset for the request path: any open request
            // is withdrawn without a handshake and queued moves are dropped.
            state_reg      <= eIDLE;
            v_reg          <= 1'b0;
            dir_reg        <= eNon;
            pend_down_reg  <= 1'b0;
            pend_left_reg  <= 1'b0;
            pend_right_reg <= 1'b0;
        end else begin
            // A new event wins over a same-cycle clear by arbitration.
            pend_down_reg  <= (pend_down_reg & ~clr_down)
                            | evt_vec[key_down_c] | grav_fire;
            pend_left_reg  <= (pend_left_reg & ~clr_left) | evt_vec[key_left_c];
            pend_right_reg <= (pend_right_reg & ~clr_right) | evt_vec[key_right_c];

            case (state_reg)
                eIDLE: begin
                    if (pick_dir != eNon) begin
                        v_reg     <= 1'b1;
                        dir_reg   <= pick_dir;
                        state_reg <= eREQ;
                    end
                end
                eREQ: begin
                    if (ready_i) begin
                        v_reg     <= 1'b0;
                        dir_reg   <= eNon;
                        state_reg <= eIDLE;
                    end
                end
                default: begin
                    v_reg     <= 1'b0;
                    dir_reg   <= eNon;
                    state_reg <= eIDLE;
                end
            endcase
        end
    end

    assign v_o         = v_reg;
    assign direction_o = dir_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// -----------------------------------------------------------------------------
// tb_move_scheduler
//
// Randomised bench for move_scheduler with a cycle-level behavioural model.
// The model keeps an elapsed-cycle count, one pending bit per direction and a
// "request outstanding" bit, and derives each cycle's expected outputs from
// the scheduling rules directly. A few directed phases (gravity cadence,
// level jump, left/right cancel, held button) precede a long random run.
// -----------------------------------------------------------------------------
module tb_move_scheduler;
    import tetris::*;

    localparam int BASE = 20;
    localparam int MIN  = 4;
    localparam int STEP = 3;
    localparam int RD   = 10;
    localparam int RP   = 5;
`ifdef MOVE_SCHEDULER_AUTOREPEAT_EN
    localparam bit REP_ON = 1'b1;
`else
    localparam bit REP_ON = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       en_i;
    logic       btn_left_i;
    logic       btn_right_i;
    logic       btn_down_i;
    logic [3:0] level_i;
    logic       v_o;
    direction_e direction_o;
    logic       ready_i;
    logic       gravity_tick_o;

    move_scheduler #(
        .base_period_p   (BASE),
        .min_period_p    (MIN),
        .level_step_p    (STEP),
        .repeat_delay_p  (RD),
        .repeat_period_p (RP)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .en_i           (en_i),
        .btn_left_i     (btn_left_i),
        .btn_right_i    (btn_right_i),
        .btn_down_i     (btn_down_i),
        .level_i        (level_i),
        .v_o            (v_o),
        .direction_o    (direction_o),
        .ready_i        (ready_i),
        .gravity_tick_o (gravity_tick_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_elapsed;
    bit         m_pend_d, m_pend_l, m_pend_r;
    bit         m_v, m_tick;
    direction_e m_dir;
    bit         m_prev_l, m_prev_r, m_prev_d;
    int         m_age_l, m_age_r;
    int         m_left_hs;
    int         dut_left_hs;

    function automatic bit rep_due(input int age);
        return REP_ON && (age >= RD) && (((age - RD) % RP) == 0);
    endfunction

    task automatic model_clear();
        m_elapsed = 0;
        m_pend_d = 0; m_pend_l = 0; m_pend_r = 0;
        m_v = 0; m_tick = 0; m_dir = eNon;
        m_age_l = 0; m_age_r = 0;
    endtask

    // Advance the model across one clock edge using the current inputs.
    task automatic model_step();
        int p;
        bit fire, ev_l, ev_r, ev_d;
        if (reset_i) begin
            model_clear();
            m_prev_l = 0; m_prev_r = 0; m_prev_d = 0;
            return;
        end
        if (!en_i) begin
            model_clear();
        end else begin
            p = BASE - int'(level_i) * STEP;
            if (p < MIN) p = MIN;
            fire = (m_elapsed >= p - 1);
            ev_l = (btn_left_i && !m_prev_l) || (btn_left_i && rep_due(m_age_l));
            ev_r = (btn_right_i && !m_prev_r) || (btn_right_i && rep_due(m_age_r));
            ev_d = (btn_down_i && !m_prev_d) || fire;

            if (m_v) begin
                if (ready_i) begin
                    if (m_dir == eLeft) m_left_hs++;
                    m_v = 0;
                    m_dir = eNon;
                end
            end else begin
                if (m_pend_l && m_pend_r) begin
                    m_pend_l = 0;
                    m_pend_r = 0;
                end
                if (m_pend_d) begin
                    m_v = 1; m_dir = eDown; m_pend_d = 0;
                end else if (m_pend_l) begin
                    m_v = 1; m_dir = eLeft; m_pend_l = 0;
                end else if (m_pend_r) begin
                    m_v = 1; m_dir = eRight; m_pend_r = 0;
                end
            end
            m_pend_l = m_pend_l || ev_l;
            m_pend_r = m_pend_r || ev_r;
            m_pend_d = m_pend_d || ev_d;

            m_tick = fire;
            m_elapsed = fire ? 0 : m_elapsed + 1;
            m_age_l = btn_left_i ? m_age_l + 1 : 0;
            m_age_r = btn_right_i ? m_age_r + 1 : 0;
        end
        m_prev_l = btn_left_i;
        m_prev_r = btn_right_i;
        m_prev_d = btn_down_i;
    endtask

    // One clock: record handshake, step the model, then compare after the edge.
    task automatic step_cycle();
        if (!reset_i && en_i && v_o && ready_i && direction_o == eLeft) dut_left_hs++;
        model_step();
        @(posedge clk_i);
        #1;
        check_eq("v_o", {31'd0, v_o}, {31'd0, m_v});
        check_eq("direction_o", 32'(direction_o), 32'(m_dir));
        check_eq("gravity_tick_o", {31'd0, gravity_tick_o}, {31'd0, m_tick});
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step_cycle();
        step_cycle();
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; en_i = 1'b1; ready_i = 1'b1; level_i = 4'd0;
        btn_left_i = 1'b0; btn_right_i = 1'b0; btn_down_i = 1'b0;
        dut_left_hs = 0; m_left_hs = 0;
        m_prev_l = 0; m_prev_r = 0; m_prev_d = 0;
        model_clear();

        // Reset state
        do_reset();
        check_eq("rst_v", {31'd0, v_o}, 32'd0);
        check_eq("rst_dir", 32'(direction_o), 32'(eNon));
        check_eq("rst_tick", {31'd0, gravity_tick_o}, 32'd0);

        // Gravity cadence at level 0: ticks at 20/40/60, eDown one cycle later
        for (int k = 1; k <= 62; k++) begin
            step_cycle();
            check_eq("grav_tick_k", {31'd0, gravity_tick_o}, (k % 20 == 0) ? 32'd1 : 32'd0);
            check_eq("grav_req_k", {31'd0, v_o}, (k % 20 == 1 && k > 1) ? 32'd1 : 32'd0);
            if (k % 20 == 1 && k > 1)
                check_eq("grav_dir_k", 32'(direction_o), 32'(eDown));
        end

        // Level jump 0 -> 5 with counter at 12: tick on the next cycle
        do_reset();
        for (int k = 0; k < 12; k++) step_cycle();
        level_i = 4'd5;
        step_cycle();
        check_eq("lvl_jump_tick", {31'd0, gravity_tick_o}, 32'd1);
        level_i = 4'd0;

        // Simultaneous left+right in idle: cancel, nothing issued
        do_reset();
        step_cycle();
        btn_left_i = 1'b1; btn_right_i = 1'b1;
        step_cycle();
        for (int k = 0; k < 4; k++) begin
            step_cycle();
            check_eq("lr_cancel_v", {31'd0, v_o}, 32'd0);
        end
        btn_left_i = 1'b0; btn_right_i = 1'b0;
        step_cycle();

        // Hold left for 100 cycles
        do_reset();
        dut_left_hs = 0; m_left_hs = 0;
        btn_left_i = 1'b1;
        for (int k = 0; k < 100; k++) step_cycle();
        btn_left_i = 1'b0;
        for (int k = 0; k < 4; k++) step_cycle();
        check_eq("hold_left_hs", 32'(dut_left_hs), 32'(m_left_hs));
`ifndef MOVE_SCHEDULER_AUTOREPEAT_EN
        check_eq("hold_left_once", 32'(dut_left_hs), 32'd1);
`endif

        // Random run
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) btn_left_i = ~btn_left_i;
            if ($urandom_range(0, 7) == 0) btn_right_i = ~btn_right_i;
            if ($urandom_range(0, 11) == 0) btn_down_i = ~btn_down_i;
            ready_i = ($urandom_range(0, 3) != 0);
            if (en_i) begin
                if ($urandom_range(0, 39) == 0) en_i = 1'b0;
            end else begin
                if ($urandom_range(0, 4) == 0) en_i = 1'b1;
            end
            if ($urandom_range(0, 199) == 0) level_i = 4'($urandom_range(0, 15));
            reset_i = (i == 1500 || i == 1501);
            step_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
